// File: rtl/bootram_loader.sv
// rtl/bootram_loader.sv - byte-stream boot RAM loader with length header, checksum and readback verify
// Streams 4*N bytes into a 4-lane 2048x32 RAM, then reads back all N words and compares the byte sum.
module bootram_loader (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [10:0] ram_ad,
   output logic [31:0] ram_din,
   output logic [3:0]  ram_wre,
   output logic        ram_ce,
   output logic        ram_oce,
   input  logic [31:0] ram_dout,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_VERIFY, S_FINISH
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_len_lo;
   logic [10:0] r_nm1;
   logic [12:0] r_bcnt;
   logic [7:0]  r_sum;
   logic [7:0]  r_csum;
   logic [7:0]  r_vsum;
   logic [11:0] r_vcnt;
   logic        r_err, r_hold, r_done, r_ce, r_oce;
   logic [3:0]  r_wre;
   logic [10:0] r_ad;
   logic [31:0] r_din;

   logic        w_accept, w_len_bad, w_last_byte, w_vlast;
   logic [15:0] w_len;
   logic [7:0]  w_dsum, w_vsum_next;

   assign s_ready  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign err      = r_err;
   assign cpu_hold = r_hold;
   assign ram_ad   = r_ad;
   assign ram_din  = r_din;
   assign ram_wre  = r_wre;
   assign ram_ce   = r_ce;
   assign ram_oce  = r_oce;

   assign w_accept    = s_valid && s_ready;
   assign w_len       = {s_data, r_len_lo};
   assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'd2048);
   // N is kept as N-1 so that N=2048 fits the 11-bit address and the last byte index is {N-1,2'b11}
   assign w_last_byte = (r_bcnt == {r_nm1, 2'b11});
   assign w_vlast     = (r_vcnt == ({1'b0, r_nm1} + 12'd1));
   assign w_dsum      = ram_dout[7:0] + ram_dout[15:8] + ram_dout[23:16] + ram_dout[31:24];
   assign w_vsum_next = r_vsum + w_dsum;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_LEN_LO;
         S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
         S_LEN_HI: if (w_accept) w_next = w_len_bad ? S_IDLE : S_DATA;
         S_DATA:   if (w_accept && w_last_byte) w_next = S_CSUM;
         S_CSUM:   if (w_accept) w_next = S_VERIFY;
         S_VERIFY: if (w_vlast) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_len_lo <= '0;
         r_nm1    <= '0;
         r_bcnt   <= '0;
         r_sum    <= '0;
         r_csum   <= '0;
         r_vsum   <= '0;
         r_vcnt   <= '0;
         r_err    <= 1'b0;
         r_hold   <= 1'b0;
         r_done   <= 1'b0;
         r_ce     <= 1'b0;
         r_oce    <= 1'b0;
         r_wre    <= '0;
         r_ad     <= '0;
         r_din    <= '0;
      end else begin
         r_ce   <= 1'b0;
         r_oce  <= 1'b0;
         r_wre  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_err  <= 1'b0;
               r_hold <= 1'b1;
               r_bcnt <= '0;
               r_sum  <= '0;
               r_vsum <= '0;
               r_vcnt <= '0;
            end
            S_LEN_LO: if (w_accept) r_len_lo <= s_data;
            S_LEN_HI: if (w_accept) begin
               if (w_len_bad) r_err <= 1'b1;
               else           r_nm1 <= w_len[10:0] - 11'd1;
            end
            S_DATA: if (w_accept) begin
               r_ce   <= 1'b1;
               r_wre  <= 4'b0001 << r_bcnt[1:0];
               r_ad   <= r_bcnt[12:2];
               r_din  <= {4{s_data}};
               r_sum  <= r_sum + s_data;
               r_bcnt <= r_bcnt + 13'd1;
            end
            S_CSUM: if (w_accept) begin
               r_csum <= s_data;
               r_ad   <= '0;
               r_ce   <= 1'b1;
               r_oce  <= 1'b1;
            end
            S_VERIFY: begin
               r_vcnt <= r_vcnt + 12'd1;
               // read data for address r_vcnt-1 is on ram_dout whenever r_vcnt is nonzero
               if (r_vcnt != 12'd0) r_vsum <= w_vsum_next;
               if (r_vcnt < {1'b0, r_nm1}) begin
                  r_ad  <= r_vcnt[10:0] + 11'd1;
                  r_ce  <= 1'b1;
                  r_oce <= 1'b1;
               end
               if (w_vlast) begin
                  if (w_vsum_next == r_csum) begin
                     r_done <= 1'b1;
                     r_hold <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bootram_loader.sv
// tb/tb_bootram_loader.sv - randomized self-checking bench for bootram_loader against a session-level model
module tb_bootram_loader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [10:0] ram_ad;
   logic [31:0] ram_din;
   logic [3:0]  ram_wre;
   logic        ram_ce, ram_oce;
   logic [31:0] ram_dout = 32'h0;
   logic        cpu_hold, busy, done, err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bootram_loader dut (
      .clk(clk), .resetn(resetn), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .ram_ad(ram_ad), .ram_din(ram_din), .ram_wre(ram_wre),
      .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_dout(ram_dout), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err)
   );

   // RAM: four byte lanes, registered read output
   logic [31:0] mem [0:2047];
   always @(posedge clk) begin
      if (ram_ce) begin
         for (int k = 0; k < 4; k++)
            if (ram_wre[k]) mem[ram_ad][8*k +: 8] = ram_din[8*k +: 8];
         if (ram_wre == 4'b0) ram_dout <= mem[ram_ad];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Session-level model: counts accepted bytes and derives every expectation from that count
   bit         m_active, m_fin, m_done, m_err, m_hold, m_wr;
   int         m_acc, m_n, m_v, m_sum, m_c;
   logic [7:0] m_lo;
   logic [3:0] m_wre;
   logic [10:0] m_ad;
   logic [31:0] m_din;

   function automatic bit m_ready();
      return m_active && !m_fin && (m_v < 0);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_active = 0; m_fin = 0; m_done = 0; m_err = 0; m_hold = 0; m_wr = 0;
         m_acc = 0; m_n = 0; m_v = -1; m_sum = 0; m_c = 0; m_lo = 0;
         m_wre = 0; m_ad = 0; m_din = 0;
      end else begin
         automatic bit rdy = m_ready();
         m_done = 0;
         m_wr = 0;
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_err = 0; m_hold = 1; m_acc = 0; m_sum = 0; m_v = -1; m_fin = 0;
            end
         end else if (m_fin) begin
            m_active = 0; m_fin = 0;
         end else if (m_v >= 0) begin
            if (m_v == m_n) begin
               m_v = -1; m_fin = 1;
               if (m_sum == m_c) begin m_done = 1; m_hold = 0; end
               else m_err = 1;
            end else m_v++;
         end else if (rdy && s_valid) begin
            if (m_acc == 0) m_lo = s_data;
            else if (m_acc == 1) begin
               m_n = {s_data, m_lo};
               if (m_n == 0 || m_n > 2048) begin m_err = 1; m_active = 0; end
            end else if (m_acc < 2 + 4 * m_n) begin
               automatic int b = m_acc - 2;
               m_wr = 1; m_wre = 4'b1 << (b % 4); m_ad = 11'(b / 4); m_din = {4{s_data}};
               m_sum = (m_sum + s_data) % 256;
            end else begin
               m_c = s_data; m_v = 0;
            end
            m_acc++;
         end
      end
   end

   int busy_cycles, done_cnt, wr_cnt, oce_cnt;
   logic [10:0] last_ad;
   logic [3:0]  last_wre;

   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_outputs", {busy, done, err, cpu_hold, s_ready, ram_ce, ram_oce, ram_wre}, 32'h0);
         chk("rst_ad_din", {ram_ad, ram_din[20:0]} | ram_din[31:21], 32'h0);
      end else begin
         chk("busy", busy, m_active);
         chk("s_ready", s_ready, m_ready());
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("cpu_hold", cpu_hold, m_hold);
         if (m_wr) begin
            chk("wr_ctl", {ram_ce, ram_oce, ram_wre}, {1'b1, 1'b0, m_wre});
            chk("wr_ad", ram_ad, m_ad);
            chk("wr_din", ram_din, m_din);
         end else if (m_v >= 0 && m_v < m_n) begin
            chk("rd_ctl", {ram_ce, ram_oce, ram_wre}, 6'b110000);
            chk("rd_ad", ram_ad, m_v);
         end else begin
            chk("quiet_ctl", {ram_ce, ram_oce, ram_wre}, 6'b0);
         end
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (ram_oce) oce_cnt++;
         if (ram_wre != 4'b0) begin wr_cnt++; last_ad = ram_ad; last_wre = ram_wre; end
      end
   end

   bit noise_start = 0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      busy_cycles = 0; done_cnt = 0; wr_cnt = 0; oce_cnt = 0; last_ad = 0; last_wre = 0;
   endtask

   task automatic do_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      bit acc = 0;
      while ($urandom_range(99) < gap) begin
         s_valid = 0; s_data = 8'($urandom);
         start = noise_start && ($urandom_range(15) == 0);
         tick();
      end
      start = 0;
      s_valid = 1; s_data = d;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      s_valid = 0;
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int t = 0; t < 5000 && !idle; t++) begin
         @(negedge clk);
         idle = !busy;
      end
      if (!idle) chk("idle_timeout", 0, 1);
      tick();
   endtask

   task automatic run_session(input logic [15:0] len, input int gap, input bit fixed, input bit bad_csum);
      logic [7:0] d, cs;
      cs = 0;
      do_start();
      send_byte(len[7:0], gap);
      send_byte(len[15:8], gap);
      if (len != 0 && len <= 2048) begin
         for (int i = 0; i < 4 * int'(len); i++) begin
            d = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom);
            cs = cs + d;
            send_byte(d, gap);
         end
         send_byte(bad_csum ? (cs ^ 8'h5a) : cs, gap);
      end
      wait_idle();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      resetn = 1;
      tick();

      // directed single-word load, stream 01 00 11 22 33 44 AA
      clr();
      run_session(16'h0001, 0, 1, 0);
      chk("t1_busy_cycles", busy_cycles, 10);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_wr_cnt", wr_cnt, 4);
      chk("t1_oce_cnt", oce_cnt, 1);
      chk("t1_mem0", mem[0], 32'h44332211);
      chk("t1_model_csum", m_c, 32'hAA);
      chk("t1_err_hold", {err, cpu_hold}, 2'b00);

      // zero length
      clr();
      run_session(16'h0000, 0, 0, 0);
      chk("t2_err_hold", {err, cpu_hold}, 2'b11);
      chk("t2_wr_cnt", wr_cnt, 0);
      chk("t2_busy_cycles", busy_cycles, 2);

      // N = 2049
      clr();
      run_session(16'h0801, 0, 0, 0);
      chk("t3_err_hold", {err, cpu_hold}, 2'b11);
      chk("t3_wr_cnt", wr_cnt, 0);

      // wrong checksum, then a correct session releases the CPU
      clr();
      run_session(16'h0001, 20, 0, 1);
      chk("t4_done_cnt", done_cnt, 0);
      chk("t4_err_hold", {err, cpu_hold}, 2'b11);
      clr();
      run_session(16'h0003, 20, 0, 0);
      chk("t4b_done_cnt", done_cnt, 1);
      chk("t4b_err_hold", {err, cpu_hold}, 2'b00);
      chk("t4b_wr_cnt", wr_cnt, 12);

      // full 2048-word load with random gaps and ignored start pulses
      clr();
      noise_start = 1;
      run_session(16'h0800, 30, 0, 0);
      noise_start = 0;
      chk("t5_last_ad", last_ad, 11'h7FF);
      chk("t5_last_wre", last_wre, 4'b1000);
      chk("t5_wr_cnt", wr_cnt, 8192);
      chk("t5_oce_cnt", oce_cnt, 2048);
      chk("t5_done_cnt", done_cnt, 1);
      chk("t5_err_hold", {err, cpu_hold}, 2'b00);

      // reset dropped while the fifth data byte's write is on the bus
      clr();
      do_start();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
      #1 resetn = 0;
      #1;
      chk("t6_async_ctl", {busy, s_ready, cpu_hold, ram_ce, ram_wre}, 8'h0);
      chk("t6_async_ad", ram_ad, 11'h0);
      repeat (3) tick();
      chk("t6_wr_cnt", wr_cnt, 4);
      resetn = 1;
      tick();
      clr();
      run_session(16'h0002, 10, 0, 0);
      chk("t6_fresh_done", done_cnt, 1);
      chk("t6_fresh_wr_cnt", wr_cnt, 8);
      chk("t6_fresh_err_hold", {err, cpu_hold}, 2'b00);

      // a few random short sessions
      for (int s = 0; s < 6; s++) begin
         automatic logic [15:0] len = 16'($urandom_range(1, 12));
         automatic bit bad = ($urandom_range(2) == 0);
         clr();
         run_session(len, 25, 0, bad);
         chk("rnd_done", done_cnt, bad ? 0 : 1);
         chk("rnd_wr_cnt", wr_cnt, 4 * int'(len));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
